// File: rtl/noise_injector.sv
// Streaming RGB noise stage: corrupts pixels with salt/pepper or additive noise
// driven by an external random word, with a registered output and one-entry skid buffer.
module noise_injector #(
  parameter int CH_W  = 8,
  parameter int CH_N  = 3,
  parameter int CNT_W = 24,
  localparam int PIX_W = CH_W * CH_N
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      rnd,
  input  logic             cfg_en,
  input  logic [1:0]       cfg_mode,
  input  logic [7:0]       cfg_density,
  input  logic [2:0]       cfg_shift,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_sof,
  input  logic             s_eof,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_sof,
  output logic             m_eof,
  output logic [CNT_W-1:0] frame_noise_cnt,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    ModeSaltPepper = 2'b00,
    ModeSalt       = 2'b01,
    ModePepper     = 2'b10,
    ModeAdditive   = 2'b11
  } noiseMode_t;

  logic             sReady_q, sReady_d;
  logic             mValid_q, mValid_d;
  logic [PIX_W-1:0] mData_q, mData_d;
  logic             mSof_q, mSof_d, mEof_q, mEof_d;
  logic             skidFull_q, skidFull_d;
  logic [PIX_W-1:0] skidData_q, skidData_d;
  logic             skidSof_q, skidSof_d, skidEof_q, skidEof_d;
  logic             en_q, en_d;
  noiseMode_t       mode_q, mode_d;
  logic [7:0]       density_q, density_d;
  logic [2:0]       shift_q, shift_d;
  logic             inFrame_q, inFrame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] frameCnt_q, frameCnt_d;
  logic             frameDone_q, frameDone_d;

  logic             accept, outFree, hit;
  logic             enEff;
  noiseMode_t       modeEff;
  logic [7:0]       densityEff;
  logic [2:0]       shiftEff;
  logic signed [7:0]      off;
  logic signed [CH_W+1:0] offExt;
  logic [PIX_W-1:0] addData, modData, pixOut;
  logic [CNT_W-1:0] cntBase, cntNext;
  logic             unused_rnd;

  assign unused_rnd = ^{rnd[31:24], rnd[15:9]};

  assign accept  = s_valid & sReady_q;
  assign outFree = ~mValid_q | m_ready;

  // A sof beat uses the configuration presented with it, not the stale latched one.
  assign enEff      = s_sof ? cfg_en : en_q;
  assign modeEff    = s_sof ? noiseMode_t'(cfg_mode) : mode_q;
  assign densityEff = s_sof ? cfg_density : density_q;
  assign shiftEff   = s_sof ? cfg_shift : shift_q;

  assign hit    = enEff & (rnd[7:0] < densityEff);
  assign off    = $signed(rnd[23:16]) >>> shiftEff;
  assign offExt = (CH_W+2)'(off);

  for (genvar c = 0; c < CH_N; c++) begin : g_ch
    logic signed [CH_W+1:0] sum;
    assign sum = $signed({2'b00, s_data[c*CH_W +: CH_W]}) + offExt;
    assign addData[c*CH_W +: CH_W] = sum[CH_W+1] ? '0 : (sum[CH_W] ? '1 : sum[CH_W-1:0]);
  end

  always_comb begin
    modData = '0;
    case (modeEff)
      ModeSaltPepper: modData = rnd[8] ? '1 : '0;
      ModeSalt:       modData = '1;
      ModePepper:     modData = '0;
      ModeAdditive:   modData = addData;
      default:        modData = '0;
    endcase
    pixOut = hit ? modData : s_data;
  end

  assign cntBase = s_sof ? '0 : cnt_q;
  assign cntNext = (hit && (cntBase != '1)) ? cntBase + 1'b1 : cntBase;

  // Next-state: skid drains first; s_ready only ever rises when the skid is empty.
  always_comb begin
    mValid_d    = mValid_q;
    mData_d     = mData_q;
    mSof_d      = mSof_q;
    mEof_d      = mEof_q;
    skidFull_d  = skidFull_q;
    skidData_d  = skidData_q;
    skidSof_d   = skidSof_q;
    skidEof_d   = skidEof_q;
    en_d        = en_q;
    mode_d      = mode_q;
    density_d   = density_q;
    shift_d     = shift_q;
    inFrame_d   = inFrame_q;
    cnt_d       = cnt_q;
    frameCnt_d  = frameCnt_q;
    frameDone_d = 1'b0;

    if (outFree) begin
      if (skidFull_q) begin
        mValid_d   = 1'b1;
        mData_d    = skidData_q;
        mSof_d     = skidSof_q;
        mEof_d     = skidEof_q;
        skidFull_d = 1'b0;
      end else if (accept) begin
        mValid_d = 1'b1;
        mData_d  = pixOut;
        mSof_d   = s_sof;
        mEof_d   = s_eof;
      end else begin
        mValid_d = 1'b0;
      end
    end else if (accept) begin
      skidFull_d = 1'b1;
      skidData_d = pixOut;
      skidSof_d  = s_sof;
      skidEof_d  = s_eof;
    end

    if (accept) begin
      if (s_sof) begin
        en_d      = cfg_en;
        mode_d    = noiseMode_t'(cfg_mode);
        density_d = cfg_density;
        shift_d   = cfg_shift;
      end
      cnt_d     = cntNext;
      inFrame_d = (s_sof | inFrame_q) & ~s_eof;
      if (s_eof && (s_sof || inFrame_q)) begin
        frameCnt_d  = cntNext;
        frameDone_d = 1'b1;
      end
    end

    sReady_d = ~skidFull_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sReady_q    <= 1'b0;
      mValid_q    <= 1'b0;
      mData_q     <= '0;
      mSof_q      <= 1'b0;
      mEof_q      <= 1'b0;
      skidFull_q  <= 1'b0;
      skidData_q  <= '0;
      skidSof_q   <= 1'b0;
      skidEof_q   <= 1'b0;
      en_q        <= 1'b0;
      mode_q      <= ModeSaltPepper;
      density_q   <= '0;
      shift_q     <= '0;
      inFrame_q   <= 1'b0;
      cnt_q       <= '0;
      frameCnt_q  <= '0;
      frameDone_q <= 1'b0;
    end else begin
      sReady_q    <= sReady_d;
      mValid_q    <= mValid_d;
      mData_q     <= mData_d;
      mSof_q      <= mSof_d;
      mEof_q      <= mEof_d;
      skidFull_q  <= skidFull_d;
      skidData_q  <= skidData_d;
      skidSof_q   <= skidSof_d;
      skidEof_q   <= skidEof_d;
      en_q        <= en_d;
      mode_q      <= mode_d;
      density_q   <= density_d;
      shift_q     <= shift_d;
      inFrame_q   <= inFrame_d;
      cnt_q       <= cnt_d;
      frameCnt_q  <= frameCnt_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign s_ready         = sReady_q;
  assign m_valid         = mValid_q;
  assign m_data          = mData_q;
  assign m_sof           = mSof_q;
  assign m_eof           = mEof_q;
  assign frame_noise_cnt = frameCnt_q;
  assign frame_done      = frameDone_q;

endmodule

// File: tb/tb_noise_injector.sv
// Directed bench for noise_injector: hand-computed pixels, handshake and frame statistics.
module tb_noise_injector;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] rnd;
  logic        cfg_en;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_density;
  logic [2:0]  cfg_shift;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        s_sof;
  logic        s_eof;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;
  logic        m_sof;
  logic        m_eof;
  logic [23:0] frame_noise_cnt;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  noise_injector dut (
    .clk(clk), .resetn(resetn), .rnd(rnd),
    .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_density(cfg_density), .cfg_shift(cfg_shift),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof), .s_eof(s_eof),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eof(m_eof),
    .frame_noise_cnt(frame_noise_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Drive one cycle of input, then observe 1 time unit after the edge.
  task automatic applyStimulus(input logic v, input logic [23:0] d, input logic sof,
                               input logic eof, input logic [31:0] r);
    s_valid = v;
    s_data  = d;
    s_sof   = sof;
    s_eof   = eof;
    rnd     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBeat(input string tag, input logic [23:0] d, input logic sof, input logic eof);
    checkOutput({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
    checkOutput({tag, "_data"}, {8'd0, m_data}, {8'd0, d});
    checkOutput({tag, "_sofeof"}, {30'd0, m_sof, m_eof}, {30'd0, sof, eof});
  endtask

  initial begin
    resetn = 1'b0; rnd = '0; cfg_en = 1'b0; cfg_mode = 2'b00; cfg_density = 8'h00; cfg_shift = 3'd0;
    s_valid = 1'b0; s_data = '0; s_sof = 1'b0; s_eof = 1'b0; m_ready = 1'b1;

    #12;
    checkOutput("rst_s_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_m_data", {8'd0, m_data}, 32'd0);
    checkOutput("rst_cnt", {8'd0, frame_noise_cnt}, 32'd0);
    checkOutput("rst_done", {31'd0, frame_done}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    checkOutput("rel_s_ready", {31'd0, s_ready}, 32'd1);

    $display("[TB] frame with noise disabled");
    applyStimulus(1, 24'h102030, 1, 0, 32'h0);
    checkBeat("pass0", 24'h102030, 1, 0);
    applyStimulus(1, 24'h203040, 0, 0, 32'h0);
    checkBeat("pass1", 24'h203040, 0, 0);
    checkOutput("pass1_nodone", {31'd0, frame_done}, 32'd0);
    applyStimulus(1, 24'h304050, 0, 0, 32'h0);
    checkBeat("pass2", 24'h304050, 0, 0);
    applyStimulus(1, 24'h405060, 0, 1, 32'h0);
    checkBeat("pass3", 24'h405060, 0, 1);
    checkOutput("pass_done", {31'd0, frame_done}, 32'd1);
    checkOutput("pass_cnt", {8'd0, frame_noise_cnt}, 32'd0);
    applyStimulus(0, 24'h0, 0, 0, 32'h0);
    checkOutput("pass_done_pulse", {31'd0, frame_done}, 32'd0);
    checkOutput("pass_idle_valid", {31'd0, m_valid}, 32'd0);

    $display("[TB] salt and pepper, density 0x80");
    cfg_en = 1'b1; cfg_mode = 2'b00; cfg_density = 8'h80; cfg_shift = 3'd0;
    applyStimulus(1, 24'h123456, 1, 0, 32'h0000_0110);
    checkBeat("sp0", 24'hFFFFFF, 1, 0);
    applyStimulus(1, 24'h654321, 0, 0, 32'h0000_0090);
    checkBeat("sp1", 24'h654321, 0, 0);
    applyStimulus(1, 24'hABCDEF, 0, 0, 32'h0000_007F);
    checkBeat("sp2", 24'h000000, 0, 0);
    applyStimulus(1, 24'h0F0F0F, 0, 1, 32'h0000_0180);
    checkBeat("sp3", 24'h0F0F0F, 0, 1);
    checkOutput("sp_done", {31'd0, frame_done}, 32'd1);
    checkOutput("sp_cnt", {8'd0, frame_noise_cnt}, 32'd2);

    $display("[TB] additive noise with clamping");
    cfg_mode = 2'b11; cfg_density = 8'hFF; cfg_shift = 3'd0;
    applyStimulus(1, 24'hF00A80, 1, 0, 32'h0020_0000);
    checkBeat("add_hi", 24'hFF2AA0, 1, 0);
    applyStimulus(1, 24'h05FF10, 0, 1, 32'h00F0_0000);
    checkBeat("add_lo", 24'h00EF00, 0, 1);
    checkOutput("add_cnt", {8'd0, frame_noise_cnt}, 32'd2);
    cfg_shift = 3'd3;
    applyStimulus(1, 24'h404040, 1, 1, 32'h0080_0000);
    checkBeat("add_shift", 24'h303030, 1, 1);
    checkOutput("one_px_done", {31'd0, frame_done}, 32'd1);
    checkOutput("one_px_cnt", {8'd0, frame_noise_cnt}, 32'd1);

    $display("[TB] backpressure with skid buffer");
    cfg_en = 1'b0;
    m_ready = 1'b1;
    applyStimulus(1, 24'hA00000, 1, 0, 32'h0);
    checkBeat("bp_a0", 24'hA00000, 1, 0);
    m_ready = 1'b0;
    applyStimulus(1, 24'hA00001, 0, 0, 32'h0);
    checkBeat("bp_hold1", 24'hA00000, 1, 0);
    checkOutput("bp_ready_low", {31'd0, s_ready}, 32'd0);
    applyStimulus(1, 24'hA00002, 0, 0, 32'h0);
    checkBeat("bp_hold2", 24'hA00000, 1, 0);
    applyStimulus(1, 24'hA00002, 0, 0, 32'h0);
    checkBeat("bp_hold3", 24'hA00000, 1, 0);
    checkOutput("bp_ready_still_low", {31'd0, s_ready}, 32'd0);
    m_ready = 1'b1;
    applyStimulus(1, 24'hA00002, 0, 0, 32'h0);
    checkBeat("bp_a1", 24'hA00001, 0, 0);
    checkOutput("bp_ready_back", {31'd0, s_ready}, 32'd1);
    applyStimulus(1, 24'hA00002, 0, 0, 32'h0);
    checkBeat("bp_a2", 24'hA00002, 0, 0);
    applyStimulus(1, 24'hA00003, 0, 1, 32'h0);
    checkBeat("bp_a3", 24'hA00003, 0, 1);
    checkOutput("bp_done", {31'd0, frame_done}, 32'd1);
    applyStimulus(0, 24'h0, 0, 0, 32'h0);
    checkOutput("bp_drained", {31'd0, m_valid}, 32'd0);

    $display("[TB] mid-frame density change is ignored");
    cfg_en = 1'b1; cfg_mode = 2'b01; cfg_density = 8'h00;
    applyStimulus(1, 24'hA1A1A1, 1, 0, 32'h0);
    checkBeat("dz0", 24'hA1A1A1, 1, 0);
    cfg_density = 8'hFF;
    applyStimulus(1, 24'hB2B2B2, 0, 0, 32'h0);
    checkBeat("dz1", 24'hB2B2B2, 0, 0);
    applyStimulus(1, 24'hC3C3C3, 0, 1, 32'h0);
    checkBeat("dz2", 24'hC3C3C3, 0, 1);
    checkOutput("dz_cnt", {8'd0, frame_noise_cnt}, 32'd0);
    applyStimulus(1, 24'hD4D4D4, 1, 0, 32'h0);
    checkBeat("df0", 24'hFFFFFF, 1, 0);
    applyStimulus(1, 24'h010101, 0, 1, 32'h0);
    checkBeat("df1", 24'hFFFFFF, 0, 1);
    checkOutput("df_cnt", {8'd0, frame_noise_cnt}, 32'd2);

    $display("[TB] reset in the middle of a frame");
    cfg_mode = 2'b10; cfg_density = 8'hFF;
    applyStimulus(1, 24'h111111, 1, 0, 32'h0);
    checkBeat("mr0", 24'h000000, 1, 0);
    s_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("mr_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("mr_data", {8'd0, m_data}, 32'd0);
    checkOutput("mr_sof", {31'd0, m_sof}, 32'd0);
    checkOutput("mr_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("mr_cnt", {8'd0, frame_noise_cnt}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    checkOutput("mr_ready_back", {31'd0, s_ready}, 32'd1);
    applyStimulus(1, 24'h222222, 0, 0, 32'h0);
    checkBeat("mr1", 24'h222222, 0, 0);
    applyStimulus(1, 24'h333333, 0, 1, 32'h0);
    checkBeat("mr2", 24'h333333, 0, 1);
    checkOutput("mr_no_done", {31'd0, frame_done}, 32'd0);
    applyStimulus(0, 24'h0, 0, 0, 32'h0);
    checkOutput("mr_no_done_late", {31'd0, frame_done}, 32'd0);
    checkOutput("mr_cnt_final", {8'd0, frame_noise_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
